// File: rtl/intc.sv
// rtl/intc.sv - memory-mapped interrupt controller, up to 32 level/edge sources onto one irq.
// Optional two-flop source synchroniser enabled by defining INTC_SYNC_EN.
module intc #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               io_r,
  input  logic               io_w,
  input  logic [15:0]        io_addr,
  input  logic [31:0]        io_wdata,
  output logic [31:0]        io_rdata,
  output logic               io_hit,
  output logic               irq
);

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_EN    = 2'd1;
  localparam logic [1:0] REG_MODE  = 2'd2;
  localparam logic [1:0] REG_CLAIM = 2'd3;

  logic [NUM_IRQ-1:0] s, p, pending, enable, mode, act, pend_n, clr;
  logic [16:0]        off_full;
  logic [1:0]         sel;
  logic               wr_pend, wr_en, wr_mode, rd_claim;
  logic [4:0]         claim_idx;
  logic               claim_valid;
  logic [31:0]        claim_word, rd_val;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = irq_src;
`endif

  // 17-bit subtraction: addresses below the base wrap to a large value and miss.
  assign off_full = {1'b0, io_addr} - {1'b0, BASE_ADDR};
  assign io_hit   = (off_full < 17'd16);
  assign sel      = off_full[3:2];

  assign wr_pend  = io_w & io_hit & (sel == REG_PEND);
  assign wr_en    = io_w & io_hit & (sel == REG_EN);
  assign wr_mode  = io_w & io_hit & (sel == REG_MODE);
  assign rd_claim = io_r & io_hit & (sel == REG_CLAIM);

  assign act = pending & enable;
  assign irq = |act;

  // Descending scan so the lowest active index is the last one assigned.
  always_comb begin
    claim_idx   = '0;
    claim_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        claim_idx   = 5'(i);
        claim_valid = 1'b1;
      end
    end
  end

  assign claim_word = claim_valid ? {27'd0, claim_idx} : 32'hFFFF_FFFF;

  always_comb begin
    clr    = '0;
    pend_n = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (wr_pend & io_wdata[i]) |
               (rd_claim & claim_valid & (claim_idx == 5'(i)));
      // Edge lines: a new edge wins over any clear in the same cycle.
      pend_n[i] = mode[i] ? ((s[i] & ~p[i]) | (pending[i] & ~clr[i])) : s[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      p       <= s;
      pending <= pend_n;
      if (wr_en)   enable <= io_wdata[NUM_IRQ-1:0];
      if (wr_mode) mode   <= io_wdata[NUM_IRQ-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_PEND:  rd_val[NUM_IRQ-1:0] = pending;
      REG_EN:    rd_val[NUM_IRQ-1:0] = enable;
      REG_MODE:  rd_val[NUM_IRQ-1:0] = mode;
      default:   rd_val              = claim_word;
    endcase
    io_rdata = (io_r && io_hit) ? rd_val : '0;
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, io_wdata, off_full};

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - directed bench for intc: register table plus level/edge/priority/reset sequences.
module tb_intc;

`ifdef INTC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        io_r, io_w;
  logic [15:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_hit, irq;

  int total = 0;
  int passed = 0;

  intc #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .io_r(io_r), .io_w(io_w), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_hit(io_hit), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_w = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_w = 1'b0; io_wdata = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic h);
    io_r = 1'b1; io_addr = a;
    #1;
    d = io_rdata;
    h = io_hit;
    tick();
    io_r = 1'b0;
  endtask

  logic [31:0] d;
  logic        h;

  initial begin
    rst = 1'b1; irq_src = '0; io_r = 1'b0; io_w = 1'b0; io_addr = '0; io_wdata = '0;

    vecs[0] = '{1'b1, BASE + 16'h4,  32'hFFFF_FFFF, 32'h0,          1'b1};
    vecs[1] = '{1'b0, BASE + 16'h4,  32'h0,         32'h0000_00FF, 1'b1};
    vecs[2] = '{1'b0, BASE + 16'h6,  32'h0,         32'h0000_00FF, 1'b1};
    vecs[3] = '{1'b0, BASE + 16'h10, 32'h0,         32'h0,          1'b0};
    vecs[4] = '{1'b0, BASE - 16'h1,  32'h0,         32'h0,          1'b0};
    vecs[5] = '{1'b1, BASE + 16'h8,  32'h1234_56A5, 32'h0,          1'b1};
    vecs[6] = '{1'b0, BASE + 16'hB,  32'h0,         32'h0000_00A5, 1'b1};
    vecs[7] = '{1'b1, BASE + 16'h10, 32'hFFFF_FFFF, 32'h0,          1'b0};
    vecs[8] = '{1'b1, BASE + 16'h8,  32'h0,         32'h0,          1'b1};
    vecs[9] = '{1'b0, BASE + 16'h4,  32'h0,         32'h0000_00FF, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("irq_in_reset", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    tick();
    rd(BASE + 16'h0, d, h); chk("rst_pending", d, 32'h0);
    rd(BASE + 16'h4, d, h); chk("rst_enable",  d, 32'h0);
    rd(BASE + 16'h8, d, h); chk("rst_mode",    d, 32'h0);
    rd(BASE + 16'hC, d, h); chk("rst_claim",   d, 32'hFFFF_FFFF);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Register decode / width table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        io_w = 1'b1; io_addr = vecs[i].addr; io_wdata = vecs[i].wdata;
        #1;
        chk($sformatf("vec%0d_hit", i), {31'd0, io_hit}, {31'd0, vecs[i].exp_hit});
        tick();
        io_w = 1'b0;
      end else begin
        rd(vecs[i].addr, d, h);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_hit", i), {31'd0, h}, {31'd0, vecs[i].exp_hit});
      end
    end
    wr(BASE + 16'h4, 32'h0);

    // Level line latency and W1C immunity
    wr(BASE + 16'h4, 32'h1);
    irq_src[0] = 1'b1;
    #1;
    chk("lvl_irq_before_edge", {31'd0, irq}, 32'd0);
    repeat (LAT - 1) tick();
    chk("lvl_irq_lat_minus1", {31'd0, irq}, 32'd0);
    tick();
    chk("lvl_irq_lat", {31'd0, irq}, 32'd1);
    wr(BASE + 16'h0, 32'h1);
    rd(BASE + 16'h0, d, h); chk("lvl_w1c_ignored", d, 32'h1);
    irq_src[0] = 1'b0;
    repeat (LAT - 1) tick();
    chk("lvl_drop_lat_minus1", {31'd0, irq}, 32'd1);
    tick();
    chk("lvl_drop_lat", {31'd0, irq}, 32'd0);

    // Priority and masking on level lines 3 and 5
    irq_src = 8'h28;
    repeat (LAT + 1) tick();
    wr(BASE + 16'h4, 32'h28);
    rd(BASE + 16'hC, d, h); chk("prio_claim3", d, 32'd3);
    wr(BASE + 16'h4, 32'h20);
    rd(BASE + 16'hC, d, h); chk("prio_claim5", d, 32'd5);
    wr(BASE + 16'h4, 32'h0);
    rd(BASE + 16'hC, d, h); chk("prio_claim_none", d, 32'hFFFF_FFFF);
    chk("prio_irq_masked", {31'd0, irq}, 32'd0);
    irq_src = '0;
    repeat (LAT + 1) tick();

    // Edge line: pulse capture, claim clears, second claim empty
    wr(BASE + 16'h8, 32'h4);
    wr(BASE + 16'h4, 32'h4);
    irq_src[2] = 1'b1;
    tick();
    irq_src[2] = 1'b0;
    repeat (LAT + 1) tick();
    rd(BASE + 16'h0, d, h); chk("edge_pending", d, 32'h4);
    chk("edge_irq_held", {31'd0, irq}, 32'd1);
    rd(BASE + 16'hC, d, h); chk("edge_claim2", d, 32'd2);
    rd(BASE + 16'h0, d, h); chk("edge_pend_cleared", d, 32'h0);
    chk("edge_irq_cleared", {31'd0, irq}, 32'd0);
    rd(BASE + 16'hC, d, h); chk("edge_claim_empty", d, 32'hFFFF_FFFF);

    // Set/clear collision on edge line 1, then a plain W1C
    wr(BASE + 16'h8, 32'h6);
    irq_src[1] = 1'b1;
    repeat (LAT - 1) tick();
    wr(BASE + 16'h0, 32'h2);
    rd(BASE + 16'h0, d, h); chk("collide_set_wins", d & 32'h2, 32'h2);
    wr(BASE + 16'h0, 32'h2);
    rd(BASE + 16'h0, d, h); chk("w1c_clears_edge", d & 32'h2, 32'h0);
    irq_src = '0;
    wr(BASE + 16'h8, 32'h0);
    repeat (LAT + 1) tick();

    // Asynchronous reset drops irq before the next clock edge
    wr(BASE + 16'h4, 32'h1);
    irq_src[0] = 1'b1;
    repeat (LAT + 1) tick();
    chk("async_pre_irq", {31'd0, irq}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_irq_drop", {31'd0, irq}, 32'd0);
    tick();
    rst = 1'b0;
    irq_src = '0;
    tick();
    rd(BASE + 16'h4, d, h); chk("async_enable_cleared", d, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
